// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg
//   Shared definitions for the two-requester output-path arbiter:
//   FSM state encoding, arbitration policy constants and the hold-counter
//   width helper.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam int POL_FIXED = 0;
    localparam int POL_RR    = 1;

    // Hold counter width: $clog2(MAX_HOLD+1), never less than one bit.
    function automatic int hold_cnt_width(input int max_hold);
        int w;
        w = (max_hold > 0) ? $clog2(max_hold + 1) : 1;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux2_hold_timer.sv
// mux2_hold_timer
//   Counts consecutive cycles a grant has been held. Saturates at
//   MAX_HOLD-1; o_expired is high while the count sits at that value.
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous active-high reset
//     i_clr     clear the count (grant entry)
//     i_en      advance the count (grant held for another cycle)
//     o_expired count has reached MAX_HOLD-1
module mux2_hold_timer
    import mux2_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int              CW    = hold_cnt_width(MAX_HOLD);
    localparam logic [CW-1:0]   LIMIT = CW'(MAX_HOLD - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter
//   Two-requester arbiter that owns the select of a shared 2:1 mux.
//   Grants are registered (no combinational req->gnt path), held until the
//   owner releases or the hold limit expires with the other side waiting.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     req0, req1        requests for the output path
//     data0, data1      source data
//     gnt0, gnt1        registered grants (never both high)
//     sel               registered mux select (1 = data1)
//     out_valid         gnt0 | gnt1
//     out_data          selected data, zero when out_valid is low
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int USE_RR   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    state_t r_state;
    state_t w_next;
    logic   r_gnt0;
    logic   r_gnt1;
    logic   r_sel;
    logic   r_last_gnt;
    logic   w_tie_to1;
    logic   w_expired;
    logic   w_entry;
    logic   w_stay;

    // Tie resolution in IDLE: round-robin flips away from the last owner,
    // fixed priority always favours requester 0.
    generate
        if (USE_RR == POL_RR) begin : g_rr
            assign w_tie_to1 = ~r_last_gnt;
        end else begin : g_fixed
            assign w_tie_to1 = 1'b0;
        end
    endgenerate

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_next = w_tie_to1 ? ST_GNT1 : ST_GNT0;
                end else if (req0) begin
                    w_next = ST_GNT0;
                end else if (req1) begin
                    w_next = ST_GNT1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_GNT0: begin
                if (!req0) begin
                    w_next = req1 ? ST_GNT1 : ST_IDLE;
                end else if (req1 && w_expired) begin
                    w_next = ST_GNT1;
                end else begin
                    w_next = ST_GNT0;
                end
            end
            ST_GNT1: begin
                if (!req1) begin
                    w_next = req0 ? ST_GNT0 : ST_IDLE;
                end else if (req0 && w_expired) begin
                    w_next = ST_GNT0;
                end else begin
                    w_next = ST_GNT1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Entry covers both IDLE->GRANT and a direct GRANT->GRANT handover.
    assign w_entry = (w_next != r_state) && (w_next != ST_IDLE);
    assign w_stay  = (w_next == r_state) && (r_state != ST_IDLE);

    generate
        if (MAX_HOLD > 0) begin : g_hold
            mux2_hold_timer #(
                .MAX_HOLD (MAX_HOLD)
            ) u_hold_timer (
                .clk       (clk),
                .rst       (rst),
                .i_clr     (w_entry),
                .i_en      (w_stay),
                .o_expired (w_expired)
            );
        end else begin : g_no_hold
            assign w_expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_sel      <= 1'b0;
            r_last_gnt <= 1'b1;
        end else begin
            r_state <= w_next;
            r_gnt0  <= (w_next == ST_GNT0);
            r_gnt1  <= (w_next == ST_GNT1);
            r_sel   <= (w_next == ST_GNT1);
            if (w_entry) begin
                r_last_gnt <= (w_next == ST_GNT1);
            end
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign sel       = r_sel;
    assign out_valid = r_gnt0 | r_gnt1;
    assign out_data  = out_valid ? (r_sel ? data1 : data0) : '0;

endmodule

// File: tb/tb_mux2_arbiter.sv
module tb_mux2_arbiter;

    typedef struct {
        bit rst;
        bit r0;
        bit r1;
        bit g0;
        bit g1;
    } vec_t;

    typedef struct {
        bit         g0;
        bit         g1;
        bit         sel;
        bit         v;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, req0_a = 1'b0, req1_a = 1'b0;
    logic [7:0] d0_a = '0, d1_a = '0;
    logic       g0_a, g1_a, sel_a, v_a;
    logic [7:0] od_a;
    logic       rst_b = 1'b1, req0_b = 1'b0, req1_b = 1'b0;
    logic [7:0] d0_b = '0, d1_b = '0;
    logic       g0_b, g1_b, sel_b, v_b;
    logic [7:0] od_b;

    int compared   = 0;
    int mismatched = 0;
    bit inv_on     = 1'b0;

    vec_t rr_tab[$];
    vec_t fp_tab[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    mux2_arbiter #(.WIDTH(8), .USE_RR(1), .MAX_HOLD(4)) dut_rr (
        .clk(clk), .rst(rst_a), .req0(req0_a), .req1(req1_a),
        .data0(d0_a), .data1(d1_a), .gnt0(g0_a), .gnt1(g1_a),
        .sel(sel_a), .out_valid(v_a), .out_data(od_a)
    );

    mux2_arbiter #(.WIDTH(8), .USE_RR(0), .MAX_HOLD(4)) dut_fp (
        .clk(clk), .rst(rst_b), .req0(req0_b), .req1(req1_b),
        .data0(d0_b), .data1(d1_b), .gnt0(g0_b), .gnt1(g1_b),
        .sel(sel_b), .out_valid(v_b), .out_data(od_b)
    );

    task automatic addv(input int which, input bit rst, input bit r0, input bit r1,
                        input bit g0, input bit g1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.g0 = g0; v.g1 = g1;
        if (which == 0) rr_tab.push_back(v);
        else            fp_tab.push_back(v);
    endtask

    task automatic cmp(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, req);
        end
    endtask

    // Drive one vector, push its expectation, then pop and check after the edge.
    task automatic apply(input int which, input string name, input int idx, input vec_t v);
        logic [7:0] d0, d1;
        exp_t e;
        exp_t got;
        @(negedge clk);
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        if (which == 0) begin
            rst_a = v.rst; req0_a = v.r0; req1_a = v.r1; d0_a = d0; d1_a = d1;
        end else begin
            rst_b = v.rst; req0_b = v.r0; req1_b = v.r1; d0_b = d0; d1_b = d1;
        end
        e.g0   = v.g0;
        e.g1   = v.g1;
        e.sel  = v.g1;
        e.v    = v.g0 | v.g1;
        e.data = e.v ? (e.sel ? d1 : d0) : 8'h00;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        if (which == 0) begin
            cmp({name, ".gnt0"},      idx, {7'd0, g0_a},  {7'd0, got.g0});
            cmp({name, ".gnt1"},      idx, {7'd0, g1_a},  {7'd0, got.g1});
            cmp({name, ".sel"},       idx, {7'd0, sel_a}, {7'd0, got.sel});
            cmp({name, ".out_valid"}, idx, {7'd0, v_a},   {7'd0, got.v});
            cmp({name, ".out_data"},  idx, od_a,          got.data);
        end else begin
            cmp({name, ".gnt0"},      idx, {7'd0, g0_b},  {7'd0, got.g0});
            cmp({name, ".gnt1"},      idx, {7'd0, g1_b},  {7'd0, got.g1});
            cmp({name, ".sel"},       idx, {7'd0, sel_b}, {7'd0, got.sel});
            cmp({name, ".out_valid"}, idx, {7'd0, v_b},   {7'd0, got.v});
            cmp({name, ".out_data"},  idx, od_b,          got.data);
        end
    endtask

    // Mutual exclusion of grants on both instances, every cycle.
    always @(negedge clk) begin
        if (inv_on) begin
            compared++;
            if ((g0_a && g1_a) || (g0_b && g1_b)) begin
                mismatched++;
                $display("FAIL onehot: rr=%b%b fp=%b%b expected no double grant",
                         g0_a, g1_a, g0_b, g1_b);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1);
    end

    initial begin
        vec_t hv;

        // Round-robin, MAX_HOLD=4                rst r0 r1   g0 g1
        addv(0, 1, 1, 1, 0, 0);                 // reset with both requesting
        addv(0, 0, 1, 1, 1, 0);                 // first tie -> requester 0
        addv(0, 0, 1, 1, 1, 0);
        addv(0, 0, 1, 1, 1, 0);
        addv(0, 0, 1, 1, 1, 0);                 // 4th cycle of gnt0
        for (int k = 0; k < 4; k++) addv(0, 0, 1, 1, 0, 1);
        for (int k = 0; k < 4; k++) addv(0, 0, 1, 1, 1, 0);
        addv(0, 0, 1, 1, 0, 1);                 // v13
        for (int k = 0; k < 10; k++) addv(0, 0, 1, 0, 1, 0); // req0 alone, no limit
        addv(0, 0, 1, 1, 0, 1);                 // req1 after saturation -> switch
        addv(0, 0, 1, 1, 0, 1);
        addv(0, 0, 1, 0, 1, 0);                 // req1 releases, req0 waiting
        addv(0, 0, 0, 1, 0, 1);                 // req0 releases, no idle bubble
        addv(0, 0, 0, 0, 0, 0);                 // both low -> IDLE
        addv(0, 0, 1, 0, 1, 0);                 // last_gnt = 0
        addv(0, 0, 0, 0, 0, 0);
        addv(0, 0, 1, 1, 0, 1);                 // RR tie goes to requester 1
        addv(0, 1, 1, 1, 0, 0);                 // reset mid GRANT1
        addv(0, 0, 1, 1, 1, 0);                 // post-reset tie -> requester 0

        // Fixed priority, MAX_HOLD=4
        addv(1, 1, 1, 1, 0, 0);
        addv(1, 0, 1, 1, 1, 0);
        addv(1, 0, 0, 0, 0, 0);
        addv(1, 0, 1, 1, 1, 0);                 // last was 0, still requester 0
        addv(1, 0, 0, 0, 0, 0);
        addv(1, 0, 1, 1, 1, 0);
        addv(1, 0, 0, 0, 0, 0);
        addv(1, 0, 0, 1, 0, 1);
        addv(1, 0, 1, 1, 0, 1);                 // req0 does not preempt
        addv(1, 0, 1, 1, 0, 1);
        addv(1, 0, 1, 0, 1, 0);                 // req1 drops -> gnt0
        addv(1, 0, 1, 1, 1, 0);
        addv(1, 0, 0, 0, 0, 0);
        addv(1, 0, 1, 1, 1, 0);

        inv_on = 1'b1;
        foreach (rr_tab[i]) apply(0, "rr", i, rr_tab[i]);
        foreach (fp_tab[i]) apply(1, "fp", i, fp_tab[i]);

        // Long contention run from reset: grants alternate in blocks of four.
        hv.rst = 1'b1; hv.r0 = 1'b1; hv.r1 = 1'b1; hv.g0 = 1'b0; hv.g1 = 1'b0;
        apply(0, "alt", 0, hv);
        for (int k = 0; k < 24; k++) begin
            hv.rst = 1'b0;
            hv.g0  = ((k / 4) % 2) == 0;
            hv.g1  = !hv.g0;
            apply(0, "alt", k + 1, hv);
        end

        // Queue must be drained by the end of the run.
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL sb_drain: %0d entries left expected 0", sb.size());
        end

        inv_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
